// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framing scheduler.
//   state_e    : framing FSM states
//   HDR_BYTE   : default frame start byte
//   CH_ID_BASE : default channel ID of ch0 (ch1 sends CH_ID_BASE + 1)
//   NUM_CH     : number of packet sources
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StId,
        StLen,
        StPay,
        StCsum
    } state_e;

    localparam logic [7:0] HDR_BYTE   = 8'hAA;
    localparam logic [7:0] CH_ID_BASE = 8'h01;
    localparam int unsigned NUM_CH    = 2;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of handshake signals between the framing scheduler, its two packet
// sources and the UART byte transmitter.
//   master : scheduler view (drives grants, pops, transmitter enable/data, status)
//   slave  : environment view (sources and transmitter)
//   req0/1, len0/1, dat0/1 : source request, payload length, payload byte
//   gnt0/1, rd0/1          : grant pulse, payload pop strobe
//   txDone, txEn, txData   : transmitter handshake
//   busy, frameDone        : frame status
interface uart_tx_sched_if;

    logic       req0;
    logic       req1;
    logic [7:0] len0;
    logic [7:0] len1;
    logic [7:0] dat0;
    logic [7:0] dat1;
    logic       gnt0;
    logic       gnt1;
    logic       rd0;
    logic       rd1;
    logic       txDone;
    logic       txEn;
    logic [7:0] txData;
    logic       busy;
    logic       frameDone;

    modport master (
        input  req0, req1, len0, len1, dat0, dat1, txDone,
        output gnt0, gnt1, rd0, rd1, txEn, txData, busy, frameDone
    );

    modport slave (
        output req0, req1, len0, len1, dat0, dat1, txDone,
        input  gnt0, gnt1, rd0, rd1, txEn, txData, busy, frameDone
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
//   sysClk : clock
//   nrst   : asynchronous active-low reset
//   req_i  : request vector, bit n = channel n
//   en_i   : arbitration enabled this cycle; the winner is remembered only when set
//   gnt_o  : one-hot combinational grant (zero when no request)
// On a tie the channel that did not win last time wins; after reset ch1 is
// treated as the last winner, so ch0 takes the first tie.
module rr_arb2
    import uart_pkg::*;
(
    input  logic              sysClk,
    input  logic              nrst,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
        if (en_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge sysClk or negedge nrst) begin
        if (!nrst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Framing scheduler in front of the UART byte transmitter.
//   sysClk : system clock
//   nrst   : asynchronous active-low reset; aborts any frame in progress
//   bus    : master side of uart_tx_sched_if (sources + transmitter handshake)
// Frame on the wire: HdrByte, channel ID, len, len payload bytes, checksum.
// The checksum is the mod-256 sum of ID, len and payload. Each payload byte is
// popped from the source (rd) in the cycle the preceding byte is loaded into
// txData, and lands in the prefetch register two cycles later, well ahead of
// the transmitter's next done pulse. All outputs are registered.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter logic [7:0] HdrByte  = HDR_BYTE,
    parameter logic [7:0] ChIdBase = CH_ID_BASE
) (
    input logic             sysClk,
    input logic             nrst,
    uart_tx_sched_if.master bus
);

    state_e            state_q, state_d;
    logic              ch_q, ch_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        pf_q, pf_d;
    logic              cap_q, cap_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] rd_q, rd_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] arb_gnt;
    logic              arb_en;
    logic [NUM_CH-1:0] ch_oh;
    logic [7:0]        dat_sel;
    logic [7:0]        id_byte;
    logic [8:0]        next_idx;
    logic              done_ok;

    assign arb_req  = {bus.req1, bus.req0};
    assign arb_en   = (state_q == StIdle);
    assign ch_oh    = ch_q ? 2'b10 : 2'b01;
    assign dat_sel  = ch_q ? bus.dat1 : bus.dat0;
    assign id_byte  = ChIdBase + {7'd0, ch_q};
    // Index of the byte after the one being loaded now, widened so len 255 cannot wrap.
    assign next_idx = {1'b0, cnt_q} + 9'd1;
    // txEn is high exactly while a byte is outstanding, so it qualifies txDone.
    assign done_ok  = bus.txDone && tx_en_q;

    rr_arb2 u_arb (
        .sysClk (sysClk),
        .nrst   (nrst),
        .req_i  (arb_req),
        .en_i   (arb_en),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        csum_d       = csum_q;
        gnt_d        = '0;
        rd_d         = '0;
        tx_en_d      = tx_en_q;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        // Source data is valid the cycle after rd; capture it then.
        cap_d        = |rd_q;
        pf_d         = cap_q ? dat_sel : pf_q;

        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    state_d   = StHdr;
                    ch_d      = arb_gnt[1];
                    len_d     = arb_gnt[1] ? bus.len1 : bus.len0;
                    cnt_d     = 8'd0;
                    csum_d    = 8'd0;
                    gnt_d     = arb_gnt;
                    tx_en_d   = 1'b1;
                    tx_data_d = HdrByte;
                    busy_d    = 1'b1;
                end
            end
            StHdr: begin
                if (done_ok) begin
                    state_d   = StId;
                    tx_data_d = id_byte;
                    csum_d    = csum_q + id_byte;
                end
            end
            StId: begin
                if (done_ok) begin
                    state_d   = StLen;
                    tx_data_d = len_q;
                    csum_d    = csum_q + len_q;
                    if (len_q != 8'd0) begin
                        rd_d = ch_oh;
                    end
                end
            end
            StLen: begin
                if (done_ok) begin
                    if (len_q == 8'd0) begin
                        state_d   = StCsum;
                        tx_data_d = csum_q;
                    end else begin
                        state_d   = StPay;
                        tx_data_d = pf_q;
                        csum_d    = csum_q + pf_q;
                        cnt_d     = 8'd1;
                        if (len_q > 8'd1) begin
                            rd_d = ch_oh;
                        end
                    end
                end
            end
            StPay: begin
                if (done_ok) begin
                    if (cnt_q == len_q) begin
                        state_d   = StCsum;
                        tx_data_d = csum_q;
                    end else begin
                        tx_data_d = pf_q;
                        csum_d    = csum_q + pf_q;
                        cnt_d     = cnt_q + 8'd1;
                        if (next_idx < {1'b0, len_q}) begin
                            rd_d = ch_oh;
                        end
                    end
                end
            end
            StCsum: begin
                if (done_ok) begin
                    state_d      = StIdle;
                    tx_en_d      = 1'b0;
                    tx_data_d    = 8'd0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                tx_en_d   = 1'b0;
                tx_data_d = 8'd0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysClk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            ch_q         <= 1'b0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            csum_q       <= 8'd0;
            pf_q         <= 8'd0;
            cap_q        <= 1'b0;
            gnt_q        <= '0;
            rd_q         <= '0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= 8'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            pf_q         <= pf_d;
            cap_q        <= cap_d;
            gnt_q        <= gnt_d;
            rd_q         <= rd_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.gnt0      = gnt_q[0];
    assign bus.gnt1      = gnt_q[1];
    assign bus.rd0       = rd_q[0];
    assign bus.rd1       = rd_q[1];
    assign bus.txEn      = tx_en_q;
    assign bus.txData    = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.frameDone = frame_done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. Each source is a byte stream; a frame
// consumes len bytes from the head of the granted channel's stream. Expected
// frames are built as byte lists (header, ID, len, payload, mod-256 sum) and
// compared byte by byte against txData while the bench plays the transmitter.
module tb_uart_tx_sched;
    import uart_pkg::*;

    logic sysClk = 1'b0;
    logic nrst   = 1'b0;
    always #5 sysClk = ~sysClk;

    uart_tx_sched_if bus ();

    uart_tx_sched dut (
        .sysClk (sysClk),
        .nrst   (nrst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src_q0[$];
    logic [7:0] src_q1[$];
    logic [7:0] mdl_q0[$];
    logic [7:0] mdl_q1[$];
    int rdc0 = 0, rdc1 = 0, gc0 = 0, gc1 = 0, src_underflow = 0;
    bit last_ch = 1'b1;

    // Source model: a popped byte is presented from mid-cycle onwards, so it is
    // valid in the cycle after rd.
    always @(negedge sysClk) begin
        if (bus.rd0 === 1'b1) begin
            rdc0++;
            if (src_q0.size() > 0) bus.dat0 = src_q0.pop_front();
            else src_underflow++;
        end
        if (bus.rd1 === 1'b1) begin
            rdc1++;
            if (src_q1.size() > 0) bus.dat1 = src_q1.pop_front();
            else src_underflow++;
        end
        if (bus.gnt0 === 1'b1) gc0++;
        if (bus.gnt1 === 1'b1) gc1++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit pick(input bit r0, input bit r1);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
        return ~last_ch;
    endfunction

    task automatic load_ch(input bit ch, input int ln, input bit all_ff);
        logic [7:0] b;
        if (ch) bus.len1 = 8'(ln);
        else bus.len0 = 8'(ln);
        for (int i = 0; i < ln; i++) begin
            b = all_ff ? 8'hFF : 8'($urandom);
            if (ch) begin
                src_q1.push_back(b);
                mdl_q1.push_back(b);
            end else begin
                src_q0.push_back(b);
                mdl_q0.push_back(b);
            end
        end
    endtask

    task automatic flush_sources();
        src_q0.delete();
        src_q1.delete();
        mdl_q0.delete();
        mdl_q1.delete();
        bus.dat0 = 8'd0;
        bus.dat1 = 8'd0;
    endtask

    // drop_mode: 0 keep requests, 1 drop the granted request, 2 drop both.
    // abort_at: byte index at which reset is asserted instead of txDone (-1 none).
    task automatic do_frame(input bit exp_ch, input int drop_mode, input int abort_at,
                            input string tag);
        logic [7:0] exp[$];
        logic [7:0] sum;
        logic [7:0] id;
        logic [7:0] b;
        int ln, r0s, r1s, g0s, g1s, k, got_rd, oth_rd;
        bit got;
        r0s = rdc0; r1s = rdc1; g0s = gc0; g1s = gc1;
        ln  = exp_ch ? int'(bus.len1) : int'(bus.len0);
        id  = CH_ID_BASE + 8'(exp_ch);
        exp.push_back(HDR_BYTE);
        exp.push_back(id);
        exp.push_back(8'(ln));
        sum = id + 8'(ln);
        for (int i = 0; i < ln; i++) begin
            b = 8'd0;
            if (exp_ch && mdl_q1.size() > 0) b = mdl_q1.pop_front();
            if (!exp_ch && mdl_q0.size() > 0) b = mdl_q0.pop_front();
            exp.push_back(b);
            sum = sum + b;
        end
        exp.push_back(sum);

        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge sysClk);
            if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s gnt_timeout: got no grant within 50 cycles, required gnt%0d",
                     tag, exp_ch);
            return;
        end
        n_tests++;
        if ({bus.gnt1, bus.gnt0} !== (exp_ch ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL %s gnt_channel: got {gnt1,gnt0}=%b, required gnt%0d",
                     tag, {bus.gnt1, bus.gnt0}, exp_ch);
        end
        last_ch = exp_ch;
        if (drop_mode == 2) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end else if (drop_mode == 1) begin
            if (exp_ch) bus.req1 = 1'b0;
            else bus.req0 = 1'b0;
        end

        for (int i = 0; i < exp.size(); i++) begin
            n_tests++;
            if ({bus.txEn, bus.busy, bus.frameDone, bus.txData} !== {3'b110, exp[i]}) begin
                n_fail++;
                $display("FAIL %s byte%0d: got txEn=%b busy=%b frameDone=%b txData=%h, required 1 1 0 %h",
                         tag, i, bus.txEn, bus.busy, bus.frameDone, bus.txData, exp[i]);
            end
            if (i == abort_at) begin
                nrst = 1'b0;
                #1;
                n_tests++;
                if ({bus.txEn, bus.busy, bus.gnt0, bus.gnt1, bus.rd0, bus.rd1, bus.frameDone,
                     bus.txData} !== 15'd0) begin
                    n_fail++;
                    $display("FAIL %s abort_outputs: got txEn=%b busy=%b gnt=%b%b rd=%b%b fd=%b txData=%h, required all 0",
                             tag, bus.txEn, bus.busy, bus.gnt1, bus.gnt0, bus.rd1, bus.rd0,
                             bus.frameDone, bus.txData);
                end
                repeat (3) @(negedge sysClk);
                nrst = 1'b1;
                flush_sources();
                last_ch = 1'b1;
                return;
            end
            k = int'($urandom_range(2, 5));
            repeat (k) @(negedge sysClk);
            n_tests++;
            if (bus.txData !== exp[i] || bus.txEn !== 1'b1) begin
                n_fail++;
                $display("FAIL %s stable%0d: got txEn=%b txData=%h before txDone, required 1 %h",
                         tag, i, bus.txEn, bus.txData, exp[i]);
            end
            bus.txDone = 1'b1;
            @(negedge sysClk);
            bus.txDone = 1'b0;
        end

        n_tests++;
        if ({bus.txEn, bus.busy, bus.frameDone} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s frame_end: got txEn=%b busy=%b frameDone=%b, required 0 0 1",
                     tag, bus.txEn, bus.busy, bus.frameDone);
        end
        got_rd = exp_ch ? rdc1 - r1s : rdc0 - r0s;
        oth_rd = exp_ch ? rdc0 - r0s : rdc1 - r1s;
        n_tests++;
        if (got_rd != ln || oth_rd != 0) begin
            n_fail++;
            $display("FAIL %s rd_count: got granted=%0d other=%0d, required %0d and 0",
                     tag, got_rd, oth_rd, ln);
        end
        n_tests++;
        if ((exp_ch ? gc1 - g1s : gc0 - g0s) != 1 || (exp_ch ? gc0 - g0s : gc1 - g1s) != 0) begin
            n_fail++;
            $display("FAIL %s gnt_count: got gnt0=%0d gnt1=%0d, required exactly one gnt%0d",
                     tag, gc0 - g0s, gc1 - g1s, exp_ch);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sysClk);
        n_tests++;
        if ({bus.txEn, bus.busy, bus.gnt0, bus.gnt1, bus.rd0, bus.rd1, bus.frameDone,
             bus.txData} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got txEn=%b busy=%b txData=%h, required all 0",
                     bus.txEn, bus.busy, bus.txData);
        end
        nrst = 1'b1;
        repeat (2) @(negedge sysClk);
        n_tests++;
        if ({bus.txEn, bus.busy, bus.frameDone} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got txEn=%b busy=%b frameDone=%b, required 0 0 0",
                     bus.txEn, bus.busy, bus.frameDone);
        end
    endtask

    task automatic test_alternate();
        load_ch(1'b0, 3, 1'b0);
        load_ch(1'b0, 3, 1'b0);
        load_ch(1'b1, 2, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        do_frame(pick(1'b1, 1'b1), 0, -1, "alt0");
        do_frame(pick(1'b1, 1'b1), 0, -1, "alt1");
        do_frame(pick(1'b1, 1'b1), 2, -1, "alt2");
        flush_sources();
    endtask

    task automatic test_single();
        bus.len0 = 8'd2;
        src_q0.push_back(8'h10); mdl_q0.push_back(8'h10);
        src_q0.push_back(8'h20); mdl_q0.push_back(8'h20);
        bus.req0 = 1'b1;
        do_frame(pick(1'b1, 1'b0), 1, -1, "single");
    endtask

    task automatic test_len0();
        load_ch(1'b1, 0, 1'b0);
        bus.req1 = 1'b1;
        do_frame(pick(1'b0, 1'b1), 1, -1, "len0");
    endtask

    task automatic test_wrap();
        load_ch(1'b0, 3, 1'b1);
        bus.req0 = 1'b1;
        do_frame(pick(1'b1, 1'b0), 1, -1, "wrap");
    endtask

    task automatic test_idle_done();
        for (int i = 0; i < 4; i++) begin
            bus.txDone = 1'b1;
            @(negedge sysClk);
            bus.txDone = 1'b0;
            n_tests++;
            if ({bus.txEn, bus.busy, bus.gnt0, bus.gnt1, bus.rd0, bus.rd1, bus.frameDone}
                    !== 7'd0) begin
                n_fail++;
                $display("FAIL idle_done%0d: got txEn=%b busy=%b gnt=%b%b rd=%b%b fd=%b, required all 0",
                         i, bus.txEn, bus.busy, bus.gnt1, bus.gnt0, bus.rd1, bus.rd0,
                         bus.frameDone);
            end
            @(negedge sysClk);
        end
        load_ch(1'b1, 1, 1'b0);
        bus.req1 = 1'b1;
        do_frame(pick(1'b0, 1'b1), 1, -1, "after_idle_done");
    endtask

    task automatic test_abort();
        load_ch(1'b0, 5, 1'b0);
        bus.req0 = 1'b1;
        do_frame(pick(1'b1, 1'b0), 1, 4, "abort");
        @(negedge sysClk);
        load_ch(1'b0, 2, 1'b0);
        load_ch(1'b1, 2, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        do_frame(pick(1'b1, 1'b1), 2, -1, "post_abort_tie");
        flush_sources();
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 6; it++) begin
            r = int'($urandom_range(1, 3));
            if (r[0]) load_ch(1'b0, int'($urandom_range(0, 12)), 1'b0);
            if (r[1]) load_ch(1'b1, int'($urandom_range(0, 12)), 1'b0);
            bus.req0 = r[0];
            bus.req1 = r[1];
            do_frame(pick(r[0], r[1]), 2, -1, "random");
            repeat (int'($urandom_range(0, 3))) @(negedge sysClk);
        end
    endtask

    initial begin
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.len0   = 8'd0;
        bus.len1   = 8'd0;
        bus.dat0   = 8'd0;
        bus.dat1   = 8'd0;
        bus.txDone = 1'b0;
        test_reset();
        test_alternate();
        test_single();
        test_len0();
        test_wrap();
        test_idle_done();
        test_abort();
        test_random();
        n_tests++;
        if (src_underflow != 0) begin
            n_fail++;
            $display("FAIL src_underflow: got %0d pops from empty source, required 0",
                     src_underflow);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
